// File: rtl/hls_deadlock_monitor_gen_if.sv
// Monitor-side bundle for one HLS deadlock monitor: blocking/idle flags in,
// block status, offending sources and event count out.
interface hls_deadlock_monitor_gen_if #(
    parameter int N_AXIS = 3,
    parameter int N_SUB  = 1,
    parameter int EVT_W  = 8
);
    localparam int SUB_W = (N_SUB > 0) ? N_SUB : 1;

    logic [N_AXIS-1:0]       axis_block_sigs;
    logic [SUB_W-1:0]        inst_block_sigs;
    logic [SUB_W-1:0]        inst_idle_sigs;
    logic                    clear;
    logic                    block;
    logic [N_AXIS+N_SUB-1:0] block_src;
    logic [EVT_W-1:0]        block_events;

    // Side that drives the flags and observes the verdict.
    modport master (
        output axis_block_sigs, inst_block_sigs, inst_idle_sigs, clear,
        input  block, block_src, block_events
    );

    // The monitor itself.
    modport slave (
        input  axis_block_sigs, inst_block_sigs, inst_idle_sigs, clear,
        output block, block_src, block_events
    );
endinterface

// File: rtl/hls_deadlock_monitor_gen.sv
// Deadlock monitor for one HLS instance. A raw block condition (any AXIS
// channel blocked, or every sub-instance blocked-or-idle with at least one
// blocked) must persist THRESH consecutive cycles before block asserts.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no raw block condition being tracked
// ST_SUSPECT | raw condition seen for cnt_q consecutive cycles (< THRESH)
// ST_BLOCKED | deadlock reported; block_src accumulates offending sources
module hls_deadlock_monitor_gen #(
    parameter int N_AXIS = 3,
    parameter int N_SUB  = 1,
    parameter int THRESH = 1,
    parameter int STICKY = 0,
    parameter int EVT_W  = 8
) (
    input logic                       clock,
    input logic                       reset,
    hls_deadlock_monitor_gen_if.slave mon_if
);
    localparam int CNT_W = $clog2(THRESH + 1);
    localparam int SRC_W = N_AXIS + N_SUB;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);
    localparam logic [EVT_W-1:0] EVT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [EVT_W-1:0] evt_q, evt_d;

    logic             sub_all;
    logic             raw;
    logic             enter_blocked;
    logic [SRC_W-1:0] src_vec;

    if (N_SUB > 0) begin : g_sub
        logic [N_SUB-1:0] sub_blk;
        logic [N_SUB-1:0] sub_idl;
        assign sub_blk = mon_if.inst_block_sigs[N_SUB-1:0];
        assign sub_idl = mon_if.inst_idle_sigs[N_SUB-1:0];
        // Sub path only counts when no sub-instance is still doing useful work.
        assign sub_all = (&(sub_blk | sub_idl)) & (|sub_blk);
        assign src_vec = {sub_blk & {N_SUB{sub_all}}, mon_if.axis_block_sigs};
    end else begin : g_nosub
        logic unused_sub;
        assign unused_sub = ^{mon_if.inst_block_sigs, mon_if.inst_idle_sigs};
        assign sub_all    = 1'b0;
        assign src_vec    = mon_if.axis_block_sigs;
    end

    assign raw = (|mon_if.axis_block_sigs) | sub_all;

    // Next-state, persistence counter, source capture and event count.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        src_d         = src_q;
        enter_blocked = 1'b0;
        if (mon_if.clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            src_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (raw) begin
                        if (THRESH == 1) begin
                            state_d       = ST_BLOCKED;
                            src_d         = src_vec;
                            enter_blocked = 1'b1;
                        end else begin
                            state_d = ST_SUSPECT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!raw) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d       = ST_BLOCKED;
                        src_d         = src_vec;
                        enter_blocked = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_BLOCKED: begin
                    src_d = src_q | src_vec;
                    if ((STICKY == 0) && !raw) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        src_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    src_d   = '0;
                end
            endcase
        end
        evt_d = evt_q;
        if (enter_blocked && (evt_q != EVT_MAX)) begin
            evt_d = evt_q + EVT_W'(1);
        end
    end

    // State and status registers; synchronous reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            evt_q   <= evt_d;
        end
    end

    assign mon_if.block        = (state_q == ST_BLOCKED);
    assign mon_if.block_src    = src_q;
    assign mon_if.block_events = evt_q;
endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
// Four monitor configurations share one stimulus stream; each is checked
// against a run-length reference model plus a few directed expectations.
module tb_hls_deadlock_monitor_gen;
    logic       clock = 1'b0;
    logic       rst;
    logic [2:0] axis;
    logic [1:0] iblk;
    logic [1:0] iidl;
    logic       clr;

    int n_assert = 0;
    int n_fail   = 0;

    // Configurations: THRESH, STICKY, N_SUB, event saturation value.
    int P_T  [4] = '{4, 2, 1, 8};
    int P_ST [4] = '{0, 1, 0, 0};
    int P_NS [4] = '{1, 0, 2, 2};
    int P_EM [4] = '{255, 255, 3, 255};

    int m_run [4];
    int m_blk [4];
    int m_src [4];
    int m_evt [4];

    logic       a_blk [4];
    logic [7:0] a_src [4];
    logic [7:0] a_evt [4];

    always #5 clock = ~clock;

    hls_deadlock_monitor_gen_if #(.N_AXIS(3), .N_SUB(1), .EVT_W(8)) if0 ();
    hls_deadlock_monitor_gen_if #(.N_AXIS(3), .N_SUB(0), .EVT_W(8)) if1 ();
    hls_deadlock_monitor_gen_if #(.N_AXIS(3), .N_SUB(2), .EVT_W(2)) if2 ();
    hls_deadlock_monitor_gen_if #(.N_AXIS(3), .N_SUB(2), .EVT_W(8)) if3 ();

    assign if0.axis_block_sigs = axis;
    assign if0.inst_block_sigs = iblk[0:0];
    assign if0.inst_idle_sigs  = iidl[0:0];
    assign if0.clear           = clr;
    assign if1.axis_block_sigs = axis;
    assign if1.inst_block_sigs = iblk[0:0];
    assign if1.inst_idle_sigs  = iidl[0:0];
    assign if1.clear           = clr;
    assign if2.axis_block_sigs = axis;
    assign if2.inst_block_sigs = iblk;
    assign if2.inst_idle_sigs  = iidl;
    assign if2.clear           = clr;
    assign if3.axis_block_sigs = axis;
    assign if3.inst_block_sigs = iblk;
    assign if3.inst_idle_sigs  = iidl;
    assign if3.clear           = clr;

    hls_deadlock_monitor_gen #(.N_AXIS(3), .N_SUB(1), .THRESH(4), .STICKY(0), .EVT_W(8))
        u0 (.clock(clock), .reset(rst), .mon_if(if0));
    hls_deadlock_monitor_gen #(.N_AXIS(3), .N_SUB(0), .THRESH(2), .STICKY(1), .EVT_W(8))
        u1 (.clock(clock), .reset(rst), .mon_if(if1));
    hls_deadlock_monitor_gen #(.N_AXIS(3), .N_SUB(2), .THRESH(1), .STICKY(0), .EVT_W(2))
        u2 (.clock(clock), .reset(rst), .mon_if(if2));
    hls_deadlock_monitor_gen #(.N_AXIS(3), .N_SUB(2), .THRESH(8), .STICKY(0), .EVT_W(8))
        u3 (.clock(clock), .reset(rst), .mon_if(if3));

    assign a_blk[0] = if0.block;
    assign a_blk[1] = if1.block;
    assign a_blk[2] = if2.block;
    assign a_blk[3] = if3.block;
    assign a_src[0] = 8'(if0.block_src);
    assign a_src[1] = 8'(if1.block_src);
    assign a_src[2] = 8'(if2.block_src);
    assign a_src[3] = 8'(if3.block_src);
    assign a_evt[0] = if0.block_events;
    assign a_evt[1] = if1.block_events;
    assign a_evt[2] = 8'(if2.block_events);
    assign a_evt[3] = if3.block_events;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: block when the raw condition has lasted THRESH cycles in a row.
    task automatic model_update();
        for (int k = 0; k < 4; k++) begin
            int mask, sub, raw, srcv, run_n, nb;
            mask = (1 << P_NS[k]) - 1;
            sub  = (P_NS[k] > 0) && ((int'(iblk | iidl) & mask) == mask) && ((int'(iblk) & mask) != 0);
            raw  = (axis != 0) || sub;
            srcv = int'(axis) | (sub ? ((int'(iblk) & mask) << 3) : 0);
            if (rst) begin
                m_run[k] = 0; m_blk[k] = 0; m_src[k] = 0; m_evt[k] = 0;
            end else if (clr) begin
                m_run[k] = 0; m_blk[k] = 0; m_src[k] = 0;
            end else begin
                run_n = raw ? ((m_run[k] + 1 > P_T[k]) ? P_T[k] : m_run[k] + 1) : 0;
                nb = P_ST[k] ? (m_blk[k] || run_n >= P_T[k]) : (run_n >= P_T[k]);
                if (nb && !m_blk[k]) begin
                    m_src[k] = srcv;
                    if (m_evt[k] < P_EM[k]) m_evt[k]++;
                end else if (nb) begin
                    m_src[k] = m_src[k] | srcv;
                end else begin
                    m_src[k] = 0;
                end
                m_blk[k] = nb;
                m_run[k] = run_n;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("u%0d.block", k), 32'(a_blk[k]), 32'(m_blk[k]));
            chk($sformatf("u%0d.block_src", k), 32'(a_src[k]), 32'(m_src[k]));
            chk($sformatf("u%0d.block_events", k), 32'(a_evt[k]), 32'(m_evt[k]));
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        foreach (m_run[k]) begin
            m_run[k] = 0; m_blk[k] = 0; m_src[k] = 0; m_evt[k] = 0;
        end
        rst = 1'b1; axis = '0; iblk = '0; iidl = '0; clr = 1'b0;
        step();
        step();
        chk("reset.u2.block", 32'(a_blk[2]), 32'd0);
        rst = 1'b0;
        step();

        // Single-cycle pulses on THRESH=1 / EVT_W=2: events saturate at 3.
        for (int i = 0; i < 5; i++) begin
            axis = 3'b010;
            step();
            chk("pulse.u2.block", 32'(a_blk[2]), 32'd1);
            chk("pulse.u2.src", 32'(a_src[2]), 32'h02);
            chk("pulse.u2.events", 32'(a_evt[2]), (i < 3) ? i + 1 : 3);
            axis = 3'b000;
            step();
            chk("pulse.u2.release", 32'(a_blk[2]), 32'd0);
            step();
        end

        // 3-cycle burst must not trip THRESH=4; 4-cycle burst must.
        axis = 3'b001;
        repeat (3) step();
        chk("burst3.u0.block", 32'(a_blk[0]), 32'd0);
        axis = 3'b000;
        step();
        axis = 3'b001;
        repeat (3) step();
        chk("burst4a.u0.block", 32'(a_blk[0]), 32'd0);
        step();
        chk("burst4.u0.block", 32'(a_blk[0]), 32'd1);
        chk("burst4.u0.events", 32'(a_evt[0]), 32'd1);
        axis = 3'b000;
        step();
        chk("burst4.u0.release", 32'(a_blk[0]), 32'd0);
        chk("sticky.u1.held", 32'(a_blk[1]), 32'd1);
        chk("sticky.u1.src", 32'(a_src[1]), 32'h01);
        clr = 1'b1;
        step();
        chk("clear.u1.block", 32'(a_blk[1]), 32'd0);
        chk("clear.u1.src", 32'(a_src[1]), 32'h00);
        clr = 1'b0;
        step();

        // Sub-instance path: blocked+idle qualifies, blocked+busy does not.
        iblk = 2'b01; iidl = 2'b10;
        step();
        chk("sub.u2.block", 32'(a_blk[2]), 32'd1);
        chk("sub.u2.src", 32'(a_src[2]), 32'h08);
        iidl = 2'b00;
        step();
        chk("subbusy.u2.block", 32'(a_blk[2]), 32'd0);
        iblk = 2'b00;
        step();

        // Reset during SUSPECT with raw held high restarts the THRESH=8 count.
        axis = 3'b001;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("rstmid.u3.block", 32'(a_blk[3]), 32'd0);
        chk("rstmid.u0.events", 32'(a_evt[0]), 32'd0);
        rst = 1'b0;
        repeat (7) step();
        chk("rstmid.u3.early", 32'(a_blk[3]), 32'd0);
        step();
        chk("rstmid.u3.block", 32'(a_blk[3]), 32'd1);
        axis = 3'b000;
        step();

        // Randomized traffic: light then heavy blocking pressure.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 350; c++) begin
                int lim;
                lim  = (ph == 0) ? 4 : 8;
                axis = ($urandom_range(0, 9) < lim) ? 3'($urandom_range(1, 7)) : 3'b000;
                iblk = 2'($urandom);
                iidl = 2'($urandom);
                clr  = ($urandom_range(0, 39) == 0);
                rst  = ($urandom_range(0, 149) == 0);
                step();
            end
        end
        rst = 1'b0; clr = 1'b0; axis = '0; iblk = '0; iidl = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
